// File: rtl/booth_pp_accum.sv
// Sequential accumulator for radix-8 Booth partial products.
// Folds NUM_PP signed partial products into one OUT_W-bit product, one add per cycle,
// with each partial product weighted by 2^(GRP_SHIFT*i).
module booth_pp_accum #(
  parameter int unsigned NUM_PP    = 11,
  parameter int unsigned PP_W      = 35,
  parameter int unsigned GRP_SHIFT = 3,
  parameter int unsigned OUT_W     = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pp_valid,
  output logic                   pp_ready,
  input  logic [NUM_PP*PP_W-1:0] pp_bus,
  output logic                   prod_valid,
  input  logic                   prod_ready,
  output logic [OUT_W-1:0]       product,
  output logic                   busy
);

  // pp_1..pp_(NUM_PP-1) are parked here; pp_0 goes straight into the accumulator.
  localparam int unsigned SrW  = (NUM_PP - 1) * PP_W;
  localparam int unsigned CntW = $clog2(NUM_PP);

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  state_e            state_q, state_d;
  logic [OUT_W-1:0]  acc_q, acc_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [SrW-1:0]    sr_q, sr_d;

  logic [OUT_W-1:0]  pp0_ext;
  logic [OUT_W-1:0]  ppk_ext;
  logic [OUT_W-1:0]  ppk_shifted;
  int unsigned       shamt;
  logic              last_pp;

  // Sign-extend the incoming pp_0 and the current head of the shift register.
  always_comb begin
    pp0_ext     = {{(OUT_W - PP_W){pp_bus[PP_W-1]}}, pp_bus[PP_W-1:0]};
    ppk_ext     = {{(OUT_W - PP_W){sr_q[PP_W-1]}}, sr_q[PP_W-1:0]};
    shamt       = GRP_SHIFT * 32'(cnt_q);
    // Bits shifted past OUT_W-1 are dropped: accumulation is modulo 2^OUT_W.
    ppk_shifted = ppk_ext << shamt;
    last_pp     = (cnt_q == CntW'(NUM_PP - 1));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (pp_valid)   state_d = StAccum;
      StAccum: if (last_pp)    state_d = StDone;
      StDone:  if (prod_ready) state_d = StIdle;
      default:                 state_d = StIdle;
    endcase
  end

  // Datapath next values: capture on accept, add-and-shift while accumulating.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    sr_d  = sr_q;
    unique case (state_q)
      StIdle: begin
        if (pp_valid) begin
          acc_d = pp0_ext;
          sr_d  = pp_bus[NUM_PP*PP_W-1:PP_W];
          cnt_d = CntW'(1);
        end
      end
      StAccum: begin
        acc_d = acc_q + ppk_shifted;
        sr_d  = {{PP_W{1'b0}}, sr_q[SrW-1:PP_W]};
        cnt_d = cnt_q + CntW'(1);
      end
      default: ;
    endcase
  end

  // Datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
      sr_q  <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      sr_q  <= sr_d;
    end
  end

  // Handshake and status outputs decoded from the state.
  always_comb begin
    pp_ready   = (state_q == StIdle);
    prod_valid = (state_q == StDone);
    busy       = (state_q != StIdle);
    product    = acc_q;
  end

endmodule

// File: tb/tb_booth_pp_accum.sv
// Directed and random checks of booth_pp_accum against a plain signed multiply.
module tb_booth_pp_accum;

  localparam int unsigned NumPp  = 11;
  localparam int unsigned PpW    = 35;
  localparam int unsigned OutW   = 64;
  localparam int unsigned BusW   = NumPp * PpW;
  localparam int unsigned NumRnd = 3000;

  logic            clk;
  logic            rst;
  logic            pp_valid;
  logic            pp_ready;
  logic [BusW-1:0] pp_bus;
  logic            prod_valid;
  logic            prod_ready;
  logic [OutW-1:0] product;
  logic            busy;

  int unsigned n_tests;
  int unsigned n_fail;
  logic [63:0] sb_q[$];

  booth_pp_accum dut (
    .clk        (clk),
    .rst        (rst),
    .pp_valid   (pp_valid),
    .pp_ready   (pp_ready),
    .pp_bus     (pp_bus),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .product    (product),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Radix-8 Booth recode of y, each digit times x, packed as 35-bit fields.
  function automatic logic [BusW-1:0] booth_bus(input logic [31:0] x, input logic [31:0] y);
    logic [BusW-1:0] b;
    logic [33:0]     ye;
    int              d;
    longint          p;
    b  = '0;
    ye = {y[31], y, 1'b0};
    for (int i = 0; i < 11; i++) begin
      d = -4 * int'(ye[3*i+3]) + 2 * int'(ye[3*i+2]) + int'(ye[3*i+1]) + int'(ye[3*i]);
      p = longint'(d) * longint'($signed(x));
      b[35*i +: 35] = p[34:0];
    end
    return b;
  endfunction

  function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y);
    return 64'(longint'($signed(x)) * longint'($signed(y)));
  endfunction

  function automatic logic [BusW-1:0] rand_bus();
    logic [415:0] r;
    for (int k = 0; k < 13; k++) r[32*k +: 32] = $urandom;
    return r[BusW-1:0];
  endfunction

  // One full transaction with an optional stall of 'stall' cycles in DONE.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input int stall,
                        input string tag);
    int          lat;
    logic [63:0] held;
    logic [63:0] exp;
    pp_bus   = booth_bus(x, y);
    pp_valid = 1'b1;
    lat = 0;
    while (!pp_ready && lat < 50) begin
      tick();
      lat++;
    end
    check({tag, " accept"}, 64'(pp_ready), 64'd1);
    tick();
    sb_q.push_back(ref_prod(x, y));
    pp_valid = 1'b0;
    check({tag, " ready_drop"}, 64'(pp_ready), 64'd0);
    lat = 0;
    while (!prod_valid && lat < 40) begin
      pp_bus = rand_bus();
      tick();
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'd10);
    held = product;
    for (int s = 0; s < stall; s++) begin
      pp_valid = 1'b1;
      pp_bus   = rand_bus();
      tick();
      check({tag, " stall_valid"}, 64'(prod_valid), 64'd1);
      check({tag, " stall_product"}, product, held);
      check({tag, " stall_ready"}, 64'(pp_ready), 64'd0);
      check({tag, " stall_busy"}, 64'(busy), 64'd1);
    end
    pp_valid = 1'b0;
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hx;
    check({tag, " product"}, product, exp);
    prod_ready = 1'b1;
    tick();
    prod_ready = 1'b0;
    check({tag, " done_valid"}, 64'(prod_valid), 64'd0);
    check({tag, " idle_ready"}, 64'(pp_ready), 64'd1);
  endtask

  initial begin
    logic [63:0] exp;
    logic [31:0] xa, ya, xb, yb;
    n_tests    = 0;
    n_fail     = 0;
    rst        = 1'b1;
    pp_valid   = 1'b0;
    prod_ready = 1'b0;
    pp_bus     = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst pp_ready", 64'(pp_ready), 64'd1);
    check("rst prod_valid", 64'(prod_valid), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst product", product, 64'd0);

    // Small directed product, then corner operands.
    run_op(32'd3, 32'd5, 0, "3x5");
    run_op(32'h8000_0000, 32'h8000_0000, 5, "min_sq");
    run_op(32'hFFFF_FFFF, 32'h7FFF_FFFF, 0, "neg1_max");
    check("const min_sq", ref_prod(32'h8000_0000, 32'h8000_0000), 64'h4000_0000_0000_0000);

    // Reset in the 4th ACCUM cycle discards the operation.
    pp_bus   = booth_bus(32'd12345, 32'hFFFF_FD5A);
    pp_valid = 1'b1;
    tick();
    sb_q.push_back(ref_prod(32'd12345, 32'hFFFF_FD5A));
    pp_valid = 1'b0;
    repeat (3) tick();
    check("midrst busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb_q.delete();
    check("midrst pp_ready", 64'(pp_ready), 64'd1);
    check("midrst prod_valid", 64'(prod_valid), 64'd0);
    check("midrst product", product, 64'd0);
    check("midrst busy", 64'(busy), 64'd0);
    run_op(32'hFFFF_FFF9, 32'd9, 0, "m7x9");

    // Back-to-back with pp_valid held high and prod_ready tied high.
    xa = 32'h1234_5678; ya = 32'h8765_4321;
    xb = 32'hFEDC_BA98; yb = 32'h0000_7FFF;
    prod_ready = 1'b1;
    pp_valid   = 1'b1;
    pp_bus     = booth_bus(xa, ya);
    tick();
    sb_q.push_back(ref_prod(xa, ya));
    check("b2b accept_a", 64'(busy), 64'd1);
    repeat (9) begin
      pp_bus = rand_bus();
      tick();
    end
    check("b2b a_not_yet", 64'(prod_valid), 64'd0);
    pp_bus = rand_bus();
    tick();
    check("b2b a_valid", 64'(prod_valid), 64'd1);
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hx;
    check("b2b a_product", product, exp);
    pp_bus = booth_bus(xb, yb);
    tick();
    check("b2b idle_at_11", 64'(pp_ready), 64'd1);
    tick();
    sb_q.push_back(ref_prod(xb, yb));
    check("b2b accept_b_at_12", 64'(pp_ready), 64'd0);
    check("b2b busy_b", 64'(busy), 64'd1);
    pp_valid = 1'b0;
    repeat (9) begin
      pp_bus = rand_bus();
      tick();
    end
    check("b2b b_not_yet", 64'(prod_valid), 64'd0);
    tick();
    check("b2b b_valid", 64'(prod_valid), 64'd1);
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hx;
    check("b2b b_product", product, exp);
    tick();
    check("b2b b_idle", 64'(pp_ready), 64'd1);
    prod_ready = 1'b0;

    // Random operands with occasional consumer stalls.
    for (int n = 0; n < NumRnd; n++) begin
      run_op($urandom, $urandom, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
             "rand");
    end

    check("sb empty", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
